// File: rtl/parity_frame_checker.sv
// Streaming frame parity checker: per-word XOR parity, frame accumulation,
// length check and a valid/ready result with a saturating failure counter.
module parity_frame_checker #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_ok,
    output logic              out_len_err,
    output logic [7:0]        out_words,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned     LEN_W    = 8;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept_c;
    logic             at_last_c;
    logic             close_c;
    logic             out_fire_c;
    logic             load_c;

    logic [LEN_W-1:0] word_cnt;
    logic             s1_valid;
    logic             s1_par;
    logic             s1_close;
    logic             s1_exp;
    logic             s1_len_err;
    logic             acc_par;
    logic [LEN_W-1:0] acc_cnt;

    assign accept_c   = in_valid & in_ready;
    assign at_last_c  = (word_cnt == LAST_IDX);
    assign close_c    = in_last | at_last_c;
    assign out_fire_c = out_valid & out_ready;
    // Result registers load once, after stage 2 has absorbed the closing word.
    assign load_c     = (state == REPORT) & ~out_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACC:     if (accept_c && close_c)  state_nxt = DRAIN;
            DRAIN:   if (s1_valid && s1_close) state_nxt = REPORT;
            REPORT:  if (out_fire_c)           state_nxt = ACC;
            default:                           state_nxt = ACC;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        if (state == ACC) begin
            in_ready = 1'b1;
        end
    end

    // Word-parity stage, frame accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_par      <= 1'b0;
            s1_close    <= 1'b0;
            s1_exp      <= 1'b0;
            s1_len_err  <= 1'b0;
            acc_par     <= 1'b0;
            acc_cnt     <= '0;
            out_valid   <= 1'b0;
            out_par     <= 1'b0;
            out_ok      <= 1'b0;
            out_len_err <= 1'b0;
            out_words   <= '0;
            err_count   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_par   <= ^in_data;
                s1_close <= close_c;
                word_cnt <= word_cnt + LEN_W'(1);
                // Expected bit and length verdict only matter for the closing word.
                if (close_c) begin
                    s1_exp     <= in_par;
                    s1_len_err <= (in_last ^ at_last_c) | (~in_last & at_last_c);
                end
            end

            if (s1_valid) begin
                acc_par <= acc_par ^ s1_par;
                acc_cnt <= acc_cnt + LEN_W'(1);
            end

            if (load_c) begin
                out_valid   <= 1'b1;
                out_par     <= acc_par;
                out_ok      <= (acc_par == s1_exp) & ~s1_len_err;
                out_len_err <= s1_len_err;
                out_words   <= acc_cnt;
            end

            // Handshake closes the frame and readies the next one.
            if (out_fire_c) begin
                out_valid <= 1'b0;
                acc_par   <= 1'b0;
                acc_cnt   <= '0;
                word_cnt  <= '0;
                if (!out_ok && (err_count != CNT_MAX)) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized and directed checks of parity_frame_checker against a
// frame-level reference model (FRAME_LEN=4, CNT_W=2).
module tb_parity_frame_checker;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_par = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_par;
    logic              out_ok;
    logic              out_len_err;
    logic [7:0]        out_words;
    logic [CNT_W-1:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_err = 0;
    logic [WORD_W-1:0] wbuf [8];
    int sat_seq [5] = '{1, 2, 3, 3, 3};

    parity_frame_checker #(
        .WORD_W   (WORD_W),
        .FRAME_LEN(FRAME_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_par     (in_par),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_par    (out_par),
        .out_ok     (out_ok),
        .out_len_err(out_len_err),
        .out_words  (out_words),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_err = 0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_err_count", 32'(err_count), 0);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = WORD_W'($urandom);
        in_last  = 1'($urandom);
        in_par   = 1'($urandom);
    endtask

    // One word presented for exactly one accepting edge.
    task automatic send_word(input logic [WORD_W-1:0] d, input logic l, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_par   = p;
        check("in_ready_before_word", 32'(in_ready), 1);
        tick();
        idle_inputs();
    endtask

    // Sends wbuf[0..n-1]; model derives the report from the frame rules.
    task automatic run_frame(input int n, input bit last_final, input logic exp,
                             input int bp, input bit gaps);
        int   lat;
        logic m_par;
        logic m_len_err;
        logic m_ok;
        logic [31:0] snap;
        m_par = 1'b0;
        for (int i = 0; i < n; i++) m_par = m_par ^ ($countones(wbuf[i]) % 2 == 1);
        m_len_err = !(n == int'(FRAME_LEN) && last_final);
        m_ok = (m_par == exp) && !m_len_err;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    idle_inputs();
                    tick();
                end
            end
            send_word(wbuf[i], (i == n - 1) && last_final,
                      (i == n - 1) ? exp : 1'($urandom));
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            check("in_ready_low_while_busy", 32'(in_ready), 0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 2);
        check("out_valid", 32'(out_valid), 1);
        check("out_par", 32'(out_par), 32'(m_par));
        check("out_ok", 32'(out_ok), 32'(m_ok));
        check("out_len_err", 32'(out_len_err), 32'(m_len_err));
        check("out_words", 32'(out_words), 32'(n));
        snap = {out_words, 20'd0, out_valid, out_par, out_ok, out_len_err};
        repeat (bp) begin
            tick();
            check("bp_stable", {out_words, 20'd0, out_valid, out_par, out_ok, out_len_err}, snap);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'($urandom);
        if (!m_ok && m_err < CNT_MAX) m_err++;
        check("post_hs_out_valid", 32'(out_valid), 0);
        check("post_hs_in_ready", 32'(in_ready), 1);
        check("err_count", 32'(err_count), 32'(m_err));
        out_ready = 1'b0;
    endtask

    task automatic load_nominal();
        wbuf[0] = 16'h0001;
        wbuf[1] = 16'h0003;
        wbuf[2] = 16'hFFFF;
        wbuf[3] = 16'h0001;
    endtask

    initial begin
        int n;
        bit lf;
        idle_inputs();
        do_reset();
        check("rst_out_words", 32'(out_words), 0);
        check("rst_out_par", 32'(out_par), 0);
        check("rst_out_ok", 32'(out_ok), 0);
        check("rst_out_len_err", 32'(out_len_err), 0);

        // Nominal, mismatch, backpressure
        load_nominal();
        run_frame(4, 1'b1, 1'b0, 0, 1'b0);
        check("nominal_ok_const", 32'(out_ok), 1);
        run_frame(4, 1'b1, 1'b1, 0, 1'b0);
        check("mismatch_cnt_const", 32'(err_count), 1);
        run_frame(4, 1'b1, 1'b0, 5, 1'b0);
        run_frame(4, 1'b1, 1'b0, 0, 1'b0);

        // Short frame and forced close
        wbuf[0] = 16'h0001;
        wbuf[1] = 16'h0001;
        run_frame(2, 1'b1, 1'b0, 0, 1'b0);
        check("short_len_err_const", 32'(out_len_err), 1);
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h0001;
        run_frame(4, 1'b0, 1'b0, 1, 1'b0);
        check("forced_len_err_const", 32'(out_len_err), 1);

        // Saturation of the 2-bit failure counter
        do_reset();
        load_nominal();
        for (int k = 0; k < 5; k++) begin
            run_frame(4, 1'b1, 1'b1, 0, 1'b0);
            check("sat_seq", 32'(err_count), 32'(sat_seq[k]));
        end

        // Reset mid-frame discards the partial frame and clears the counter
        load_nominal();
        send_word(16'h1234, 1'b0, 1'b1);
        send_word(16'h0F0F, 1'b0, 1'b1);
        do_reset();
        repeat (3) begin
            tick();
            check("no_report_after_rst", 32'(out_valid), 0);
        end
        run_frame(4, 1'b1, 1'b0, 0, 1'b0);
        check("rst_frame_words", 32'(out_words), 4);
        check("rst_frame_err_count", 32'(err_count), 0);

        // Reset while a result is pending
        load_nominal();
        for (int i = 0; i < 4; i++) send_word(wbuf[i], i == 3, 1'b1);
        tick();
        tick();
        check("pending_valid", 32'(out_valid), 1);
        do_reset();
        check("pending_dropped", 32'(out_valid), 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, FRAME_LEN);
            lf = (n < int'(FRAME_LEN)) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < n; i++) wbuf[i] = WORD_W'($urandom);
            run_frame(n, lf, 1'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
